sccb_responder: RTL and testbench
=================================

SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 SHALL have parameter DEV_WID, default 8'h42, meaning the SCCB write ID; the read ID SHALL be DEV_WID|1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on sioc/siod.
REQ-003 PCLK  input  1  system clock (10 MHz nominal).
REQ-004 PRESETN  input  1  reset, asynchronous, active-low.
REQ-005 sioc  input  1  SCCB clock from the master (100 kHz nominal).
REQ-006 siod  inout  1  SCCB data, open-drain only: drive 0 or Z, never drive 1.
REQ-007 reg_addr  output  8  register file address.
REQ-008 reg_wr_en  output  1  one-PCLK write strobe.
REQ-009 reg_wdata  output  8  write data, valid with reg_wr_en.
REQ-010 reg_rd_en  output  1  one-PCLK read strobe.
REQ-011 reg_rdata  input  8  read data, valid the PCLK cycle after reg_rd_en.
REQ-012 busy  output  1  high from START detect to STOP detect.
REQ-013 id_err  output  1  one-PCLK pulse when an ID byte matches neither write ID nor read ID.

Function
REQ-014 sioc/siod SHALL be synchronized SYNC_STAGES deep, then edge-detected; all decisions use synchronized values.
REQ-015 START is siod falling while sioc is high; STOP is siod rising while sioc is high.
REQ-016 Data bits SHALL be sampled on sioc rising edges, MSB first, 9 bits per phase.
REQ-017 FSM states are IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, WAIT_STOP.
REQ-018 START in any state -> ID, with the bit counter cleared; this covers repeated start.
REQ-019 STOP in any state -> IDLE, with siod released.
REQ-020 ID: after 8 bits, a byte equal to DEV_WID -> ID_ACK (write); equal to DEV_WID|1 -> ID_ACK (read) plus a reg_rd_en pulse with reg_addr = pointer.
REQ-021 ID: any other byte -> id_err pulse, then WAIT_STOP, with siod never driven.
REQ-022 Each *_ACK bit: pull siod low from the sioc falling edge after bit 8 until the sioc falling edge after bit 9.
REQ-023 SUB: the 8-bit sub-address SHALL load the internal pointer (reset 8'h00), then -> SUB_ACK -> WDATA.
REQ-024 STOP after SUB_ACK completes a 2-phase write: the pointer is retained and no reg_wr_en occurs.
REQ-025 WDATA: after 8 bits, pulse reg_wr_en once with reg_addr = pointer and reg_wdata = byte, then WDATA_ACK -> WAIT_STOP.
REQ-026 Extra bytes after WDATA SHALL be ignored: no ack, no write.
REQ-027 Read path: capture reg_rdata into the shift register one PCLK after reg_rd_en.
REQ-028 RDATA: release the ack at the ID_ACK-ending sioc falling edge, then drive each bit (0 -> low, 1 -> Z) from each sioc falling edge, MSB first, 8 bits.
REQ-029 RD_NA: release siod and ignore the sampled value, then -> WAIT_STOP.
REQ-030 An aborted transaction (START or STOP before a phase's 8th bit) SHALL NOT pulse reg_wr_en; the pointer keeps its last completed value.
REQ-031 reg_wr_en and reg_rd_en SHALL never both be high in the same cycle and SHALL pulse at most once per phase.

Reset
REQ-032 PRESETN low SHALL immediately set: state = IDLE, siod = Z, pointer = 8'h00, shift/bit counter = 0, reg_addr = 8'h00, reg_wdata = 8'h00, reg_wr_en = 0, reg_rd_en = 0, busy = 0, id_err = 0.
REQ-033 After PRESETN deasserts mid-transfer, the block SHALL stay in IDLE until the next START.

Structure
REQ-034 Package sccb_pkg SHALL hold the FSM state encoding, bit-count constant 9, and default IDs 8'h42/8'h43.
REQ-035 Sub-module sccb_line_sync SHALL hold the synchronizers, sioc rise/fall detect, and START/STOP detect.

Verification
REQ-036 3-phase write 0x42/0x12/0x80 -> exactly one reg_wr_en with addr 0x12, wdata 0x80; siod low in all three 9th bits.
REQ-037 2-phase write 0x42/0x0A, STOP, then read 0x43 with reg_rdata = 0x76 -> one reg_rd_en with addr 0x0A; master samples 0x76; siod Z during NA.
REQ-038 ID 0x60 -> one id_err pulse; siod never low from the responder; no strobes; busy drops at STOP.
REQ-039 Write 0x42/0x12, then repeated START after 4 data bits, then 0x43 read -> no reg_wr_en; read uses pointer 0x12.
REQ-040 PRESETN low during read bit 3 (driving 0) -> siod Z with no PCLK edge; after release, no activity until the next START.
REQ-041 Write 0x42/0x05/0x11 followed by extra byte 0x22 -> one write (0x05, 0x11); no ack on 0x22.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared FSM encoding, bit count and default device IDs for the SCCB responder
package sccb_pkg;
  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, WAIT_STOP
  } state_t;
  localparam logic [3:0] BIT_CNT = 4'd9;
  localparam logic [7:0] DEF_WID = 8'h42;
  localparam logic [7:0] DEF_RID = 8'h43;
endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: synchronizes sioc/siod into PCLK and flags sioc edges plus START/STOP conditions
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic sioc,
  input  logic siod,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] c_s, d_s;
  logic scl, c_q, d_q;
  assign scl = c_s[SYNC_STAGES-1];
  assign sda = d_s[SYNC_STAGES-1];
  assign scl_rise = scl & ~c_q;
  assign scl_fall = ~scl & c_q;
  assign start = c_q & scl & d_q & ~sda;
  assign stop = c_q & scl & ~d_q & sda;
  // Flops reset to the idle bus level so releasing reset never fakes an edge
  always_ff @(posedge PCLK or negedge PRESETN)
    if (!PRESETN) begin
      c_s <= '1;
      d_s <= '1;
      c_q <= 1'b1;
      d_q <= 1'b1;
    end else begin
      c_s <= SYNC_STAGES'({c_s, sioc});
      d_s <= SYNC_STAGES'({d_s, siod});
      c_q <= scl;
      d_q <= sda;
    end
endmodule

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB slave mapping 3-phase writes and 2-phase reads onto a one-cycle register port
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_WID = DEF_WID,
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       sioc,
  inout  wire        siod,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wdata,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       id_err
);
  state_t st;
  logic [7:0] sh, ptr, nb;
  logic [3:0] cnt;
  logic rd, rd_cap, oe, sda, scl_rise, scl_fall, start, stop;
  assign siod = oe ? 1'b0 : 1'bz;
  assign nb = {sh[6:0], sda};
  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .PCLK(PCLK), .PRESETN(PRESETN), .sioc(sioc), .siod(siod), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );
  always_ff @(posedge PCLK or negedge PRESETN)
    if (!PRESETN) begin
      st <= IDLE;
      sh <= '0;
      ptr <= '0;
      cnt <= '0;
      rd <= 1'b0;
      rd_cap <= 1'b0;
      oe <= 1'b0;
      reg_addr <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      busy <= 1'b0;
      id_err <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      id_err <= 1'b0;
      rd_cap <= reg_rd_en;
      if (rd_cap) sh <= reg_rdata;
      if (start) begin
        st <= ID;
        cnt <= '0;
        oe <= 1'b0;
        busy <= 1'b1;
      end else if (stop) begin
        st <= IDLE;
        cnt <= '0;
        oe <= 1'b0;
        busy <= 1'b0;
      end else if (scl_rise && st != IDLE && st != WAIT_STOP) begin
        cnt <= cnt + 1'b1;
        if (st inside {ID, SUB, WDATA}) sh <= nb;
        case (st)
          ID: if (cnt == 4'd7) begin
            if (nb == DEV_WID) begin
              st <= ID_ACK;
              rd <= 1'b0;
            end else if (nb == (DEV_WID | 8'h01)) begin
              st <= ID_ACK;
              rd <= 1'b1;
              reg_rd_en <= 1'b1;
              reg_addr <= ptr;
            end else begin
              st <= WAIT_STOP;
              id_err <= 1'b1;
            end
          end
          SUB: if (cnt == 4'd7) begin
            st <= SUB_ACK;
            ptr <= nb;
          end
          WDATA: if (cnt == 4'd7) begin
            st <= WDATA_ACK;
            reg_wr_en <= 1'b1;
            reg_addr <= ptr;
            reg_wdata <= nb;
          end
          RD_NA: st <= WAIT_STOP;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (st)
          ID_ACK, SUB_ACK, WDATA_ACK:
            if (cnt == 4'd8) oe <= 1'b1;
            else if (cnt == BIT_CNT) begin
              cnt <= '0;
              st <= st == SUB_ACK ? WDATA : st == WDATA_ACK ? WAIT_STOP : rd ? RDATA : SUB;
              oe <= st == ID_ACK && rd && !sh[7];
            end
          // Each fall after a sampled read bit shifts the next bit onto the line
          RDATA:
            if (cnt == 4'd8) begin
              oe <= 1'b0;
              st <= RD_NA;
            end else begin
              sh <= sh << 1;
              oe <= !sh[6];
            end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: randomized SCCB master against a pointer/register-file model of the responder
module tb_sccb_responder;
  localparam int Q = 4, H = 8;
  logic PCLK = 1'b0, PRESETN = 1'b0, sioc = 1'b1, m_low = 1'b0;
  wire siod;
  logic [7:0] reg_addr, reg_wdata, reg_rdata = 8'h00;
  logic reg_wr_en, reg_rd_en, busy, id_err;
  logic [7:0] rf [256];
  logic [7:0] m_ptr = 8'h00, wr_a = 8'h00, wr_d = 8'h00, rd_a = 8'h00;
  int n_cmp = 0, n_bad = 0, n_wr = 0, n_rd = 0, n_err = 0, n_both = 0, n_low = 0;

  pullup (siod);
  assign siod = m_low ? 1'b0 : 1'bz;

  sccb_responder dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .sioc(sioc), .siod(siod),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy), .id_err(id_err)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) if (reg_rd_en) reg_rdata <= rf[reg_addr];

  always @(negedge PCLK) begin
    if (reg_wr_en) begin n_wr++; wr_a = reg_addr; wr_d = reg_wdata; end
    if (reg_rd_en) begin n_rd++; rd_a = reg_addr; end
    if (id_err) n_err++;
    if (reg_wr_en && reg_rd_en) n_both++;
    if (!m_low && siod === 1'b0) n_low++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_low = !b; tick(Q);
    sioc = 1'b1; tick(H / 2);
    s = siod; tick(H / 2);
    sioc = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, output logic na);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      d = {d[6:0], s};
    end
    send_bit(1'b1, na);
  endtask

  task automatic start_c();
    if (!sioc) begin m_low = 1'b0; tick(Q); sioc = 1'b1; tick(Q); end
    m_low = 1'b1; tick(Q);
    sioc = 1'b0; tick(Q);
  endtask

  task automatic stop_c();
    m_low = 1'b1; tick(Q);
    sioc = 1'b1; tick(Q);
    m_low = 1'b0; tick(2 * Q);
  endtask

  task automatic t_write(input logic [7:0] sub, input logic [7:0] dat, input int mode, input logic [7:0] xb);
    int w0, r0;
    logic a;
    w0 = n_wr; r0 = n_rd;
    start_c(); chk("busy_start", busy, 1);
    send_byte(8'h42, a); chk("ack_wid", a, 0);
    send_byte(sub, a); chk("ack_sub", a, 0);
    if (mode > 0) begin send_byte(dat, a); chk("ack_wdata", a, 0); end
    if (mode > 1) begin send_byte(xb, a); chk("nack_extra", a, 1); end
    stop_c(); chk("busy_stop", busy, 0);
    m_ptr = sub;
    chk("wr_count", n_wr - w0, mode > 0 ? 1 : 0);
    chk("rd_count_w", n_rd - r0, 0);
    if (mode > 0) begin chk("wr_addr", wr_a, sub); chk("wr_data", wr_d, dat); end
  endtask

  task automatic t_read();
    int r0, w0, e0;
    logic a, na;
    logic [7:0] d;
    r0 = n_rd; w0 = n_wr; e0 = n_err;
    start_c();
    send_byte(8'h43, a); chk("ack_rid", a, 0);
    recv_byte(d, na); chk("rdata", d, rf[m_ptr]); chk("na_released", na, 1);
    stop_c(); chk("busy_stop_r", busy, 0);
    chk("rd_count", n_rd - r0, 1); chk("rd_addr", rd_a, m_ptr);
    chk("wr_count_r", n_wr - w0, 0); chk("id_err_r", n_err - e0, 0);
  endtask

  task automatic t_abort_wr(input logic [7:0] sub, input int k);
    int w0;
    logic a, s;
    w0 = n_wr;
    start_c();
    send_byte(8'h42, a); chk("ack_wid_ab", a, 0);
    send_byte(sub, a); chk("ack_sub_ab", a, 0);
    for (int i = 0; i < k; i++) send_bit(1'($urandom), s);
    m_ptr = sub;
    t_read();
    chk("wr_count_ab", n_wr - w0, 0);
  endtask

  task automatic t_abort_sub(input int k);
    int w0, r0;
    logic a, s;
    w0 = n_wr; r0 = n_rd;
    start_c();
    send_byte(8'h42, a); chk("ack_wid_as", a, 0);
    for (int i = 0; i < k; i++) send_bit(1'($urandom), s);
    stop_c(); chk("busy_stop_as", busy, 0);
    chk("strobes_as", (n_wr - w0) + (n_rd - r0), 0);
  endtask

  task automatic t_bad(input logic [7:0] id);
    int w0, r0, e0, l0;
    logic a;
    w0 = n_wr; r0 = n_rd; e0 = n_err; l0 = n_low;
    start_c();
    send_byte(id, a); chk("nack_bad_id", a, 1);
    send_byte(8'($urandom), a); chk("nack_after_bad", a, 1);
    chk("busy_bad", busy, 1);
    stop_c(); chk("busy_stop_bad", busy, 0);
    chk("id_err_count", n_err - e0, 1);
    chk("siod_low_bad", n_low - l0, 0);
    chk("strobes_bad", (n_wr - w0) + (n_rd - r0), 0);
  endtask

  task automatic t_reset_mid_read();
    int w0, r0, l0;
    logic a, s, na;
    rf[8'hA5] = 8'h00;
    t_write(8'hA5, 8'h00, 0, 8'h00);
    start_c();
    send_byte(8'h43, a); chk("ack_rid_rst", a, 0);
    send_bit(1'b1, s); send_bit(1'b1, s);
    chk("rd_bit3_low", siod, 0);
    PRESETN = 1'b0;
    #2;
    chk("rst_siod_z", siod, 1); chk("rst_busy", busy, 0); chk("rst_addr", reg_addr, 0);
    tick(3);
    PRESETN = 1'b1;
    m_ptr = 8'h00;
    w0 = n_wr; r0 = n_rd; l0 = n_low;
    for (int i = 0; i < 6; i++) send_bit(1'b1, s);
    send_bit(1'b1, na);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_low", n_low - l0, 0);
    chk("post_rst_strobes", (n_wr - w0) + (n_rd - r0), 0);
    stop_c();
  endtask

  initial begin
    int kind;
    logic [7:0] id;
    for (int i = 0; i < 256; i++) rf[i] = 8'($urandom);
    rf[8'h0A] = 8'h76;
    #12;
    chk("rst_busy0", busy, 0); chk("rst_wr_en", reg_wr_en, 0); chk("rst_rd_en", reg_rd_en, 0);
    chk("rst_id_err", id_err, 0); chk("rst_reg_addr", reg_addr, 0); chk("rst_wdata", reg_wdata, 0);
    chk("rst_siod", siod, 1);
    tick(4);
    PRESETN = 1'b1;
    tick(4);
    t_read();
    t_write(8'h12, 8'h80, 1, 8'h00);
    t_write(8'h0A, 8'h00, 0, 8'h00);
    t_read();
    t_bad(8'h60);
    t_write(8'h33, 8'h00, 0, 8'h00);
    t_abort_wr(8'h12, 4);
    t_reset_mid_read();
    t_read();
    t_write(8'h05, 8'h11, 2, 8'h22);
    t_read();
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 6);
      id = 8'($urandom);
      if (id[7:1] == 7'h21) id = id ^ 8'h80;
      case (kind)
        0: t_write(8'($urandom), 8'($urandom), 0, 8'h00);
        1: t_write(8'($urandom), 8'($urandom), 1, 8'h00);
        2: t_write(8'($urandom), 8'($urandom), 2, 8'($urandom));
        3: t_read();
        4: t_bad(id);
        5: t_abort_wr(8'($urandom), $urandom_range(1, 7));
        default: t_abort_sub($urandom_range(1, 7));
      endcase
    end
    t_read();
    chk("both_strobes", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
